// File: rtl/fir_mac_tdm.sv
// Time-multiplexed FIR equaliser: one shared MAC walks TAPS products per accepted sample,
// then presents a rounded, saturated result on a valid/ready output.
module fir_mac_tdm #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned TAPS      = 16,
  parameter int unsigned FRAC_BITS = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   xn,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    yn,
  output logic                       sat,
  output logic                       busy
);

  localparam int unsigned AW    = $clog2(TAPS);
  localparam int unsigned PW    = DATA_W + COEF_W;
  localparam int unsigned ACC_W = PW + AW;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMac  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  localparam logic signed [ACC_W-1:0] RoundConst = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] OutMax =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OutMin =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]               state_q, state_d;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]            tap_q, tap_d;
  logic signed [OUT_W-1:0]  yn_q, yn_d;
  logic                     sat_q, sat_d;

  logic                     accept, coef_wr, last_tap;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_sum, acc_rnd, acc_shr;
  logic signed [OUT_W-1:0]  yn_new;
  logic                     sat_new;

  assign accept   = in_valid && (state_q == StIdle);
  // Coefficients only change while idle; out-of-range addresses are ignored.
  assign coef_wr  = coef_we && (state_q == StIdle) && (32'(coef_addr) < TAPS);
  assign last_tap = (tap_q == AW'(TAPS - 1));

  assign prod    = PW'(x_q[tap_q]) * PW'(c_q[tap_q]);
  assign acc_sum = acc_q + ACC_W'(prod);
  assign acc_rnd = acc_sum + RoundConst;
  assign acc_shr = acc_rnd >>> FRAC_BITS;

  always_comb begin
    yn_new  = acc_shr[OUT_W-1:0];
    sat_new = 1'b0;
    if (acc_shr > OutMax) begin
      yn_new  = OutMax[OUT_W-1:0];
      sat_new = 1'b1;
    end else if (acc_shr < OutMin) begin
      yn_new  = OutMin[OUT_W-1:0];
      sat_new = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    tap_d   = tap_q;
    yn_d    = yn_q;
    sat_d   = sat_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = '0;
          tap_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_sum;
        tap_d = tap_q + AW'(1);
        if (last_tap) begin
          yn_d    = yn_new;
          sat_d   = sat_new;
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      tap_q   <= '0;
      yn_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      yn_q    <= yn_d;
      sat_q   <= sat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        x_q[0] <= xn;
        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end
      if (coef_wr) c_q[coef_addr] <= coef_wdata;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign yn        = yn_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fir_mac_tdm.sv
// Self-checking bench for fir_mac_tdm: directed tables, corner sequences and random
// samples checked against a plain-arithmetic convolution model.
module tb_fir_mac_tdm;
  localparam int TAPS = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               coef_we = 1'b0;
  logic [3:0]         coef_addr = '0;
  logic signed [15:0] coef_wdata = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] xn = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] yn;
  logic               sat;
  logic               busy;

  int errors = 0;
  int checks = 0;
  longint mx[TAPS];
  longint mc[TAPS];

  typedef struct {
    int     x;
    longint y;
    bit     s;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  fir_mac_tdm dut (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .in_valid(in_valid), .in_ready(in_ready), .xn(xn),
    .out_valid(out_valid), .out_ready(out_ready), .yn(yn), .sat(sat), .busy(busy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: direct convolution over the model delay line, round half up, clamp.
  function automatic void model_out(output longint y, output bit s);
    longint acc = 0;
    longint r;
    for (int k = 0; k < TAPS; k++) acc += mx[k] * mc[k];
    r = (acc + 8192) >>> 14;
    s = 1'b0;
    y = r;
    if (r > 32767)  begin y = 32767;  s = 1'b1; end
    if (r < -32768) begin y = -32768; s = 1'b1; end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < TAPS; k++) begin mx[k] = 0; mc[k] = 0; end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we = 1'b1; coef_addr = 4'(addr); coef_wdata = 16'(val);
    step();
    coef_we = 1'b0;
    mc[addr] = val;
  endtask

  // Feeds one sample, optionally writing a coefficient on the accept edge (acc_we) or
  // attempting one in MAC cycle 3 (mac_we). Returns the DUT result.
  task automatic run_sample(input string name, input int x, input bit acc_we,
                            input bit mac_we, input int addr, input int val,
                            output longint y_act, output bit s_act);
    int     w;
    int     lat;
    longint y_exp;
    bit     s_exp;
    w = 0;
    while (!in_ready && w < 100) begin step(); w++; end
    check({name, " in_ready_wait"}, longint'(in_ready), 1);
    in_valid = 1'b1; xn = 16'(x);
    if (acc_we) begin
      coef_we = 1'b1; coef_addr = 4'(addr); coef_wdata = 16'(val);
      mc[addr] = val;
    end
    step();
    in_valid = 1'b0; coef_we = 1'b0;
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = x;
    check({name, " busy"}, longint'({busy, in_ready}), 2);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (mac_we && lat == 2) begin
        coef_we = 1'b1; coef_addr = 4'(addr); coef_wdata = 16'(val);
      end else begin
        coef_we = 1'b0;
      end
      step();
      lat++;
    end
    coef_we = 1'b0;
    check({name, " latency"}, lat, TAPS);
    model_out(y_exp, s_exp);
    y_act = longint'(yn);
    s_act = sat;
    check({name, " yn"}, y_act, y_exp);
    check({name, " sat"}, longint'(s_act), longint'(s_exp));
    w = 0;
    while (out_valid && w < 100) begin step(); w++; end
    check({name, " out_done"}, longint'(out_valid), 0);
  endtask

  initial begin
    longint y;
    bit     s;
    longint y_hold;
    bit     s_hold;

    // Reset state
    step();
    rst_n = 1'b1;
    step();
    check("reset outputs", longint'({in_ready, out_valid, busy, sat}), 8);
    check("reset yn", longint'(yn), 0);

    // Unity tap and rounding, table-driven
    tbl[0] = '{x: 1000,  y: 1000, s: 1'b0};
    tbl[1] = '{x: -2500, y: -2500, s: 1'b0};
    tbl[2] = '{x: 8192,  y: 1,  s: 1'b0};
    tbl[3] = '{x: 8191,  y: 0,  s: 1'b0};
    tbl[4] = '{x: -8192, y: 0,  s: 1'b0};
    tbl[5] = '{x: -8193, y: -1, s: 1'b0};
    write_coef(0, 16384);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin do_reset(); write_coef(0, 1); end
      run_sample($sformatf("tbl%0d", i), tbl[i].x, 1'b0, 1'b0, 0, 0, y, s);
      check($sformatf("tbl%0d const_yn", i), y, tbl[i].y);
      check($sformatf("tbl%0d const_sat", i), longint'(s), longint'(tbl[i].s));
    end

    // Impulse response
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 1024 * (k + 1));
    for (int n = 0; n < TAPS; n++) begin
      run_sample($sformatf("imp%0d", n), (n == 0) ? 16384 : 0, 1'b0, 1'b0, 0, 0, y, s);
      check($sformatf("imp%0d const", n), y, 1024 * (n + 1));
    end

    // Saturation both directions
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    for (int n = 0; n < TAPS; n++) run_sample("satp", 32767, 1'b0, 1'b0, 0, 0, y, s);
    check("satp final", longint'({s, 1'b0}) + y, 32767 + 2);
    for (int n = 0; n < TAPS; n++) run_sample("satn", -32768, 1'b0, 1'b0, 0, 0, y, s);
    check("satn final", longint'({s, 1'b0}) + y, -32768 + 2);

    // Backpressure: hold OUT for 5 cycles with a pending input
    do_reset();
    write_coef(0, 16384);
    in_valid = 1'b1; xn = 16'sd777;
    step();
    xn = 16'sd555;
    out_ready = 1'b0;
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = 777;
    repeat (TAPS) step();
    check("bp out_valid", longint'(out_valid), 1);
    y_hold = longint'(yn);
    s_hold = sat;
    check("bp yn", y_hold, 777);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp hold%0d", c),
            longint'({out_valid, in_ready, sat}) * 100000 + longint'(yn),
            longint'({1'b1, 1'b0, s_hold}) * 100000 + y_hold);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp release", longint'({out_valid, in_ready}), 1);

    // Write dropped in MAC, then unity repeat; then write+accept on same edge
    run_sample("prot", 300, 1'b0, 1'b1, 0, 0, y, s);
    run_sample("prot_rep", 1234, 1'b0, 1'b0, 0, 0, y, s);
    check("prot_rep const", y, 1234);
    run_sample("same_edge", 1000, 1'b1, 1'b0, 0, 8192, y, s);
    check("same_edge const", y, 500);

    // Random coefficients and samples
    for (int k = 0; k < TAPS; k++) begin
      if (k % 4 == 0) write_coef(k, int'($urandom_range(65535)) - 32768);
      else write_coef(k, int'($urandom_range(4095)) - 2048);
    end
    for (int n = 0; n < 30; n++)
      run_sample($sformatf("rnd%0d", n), int'($urandom_range(65535)) - 32768,
                 1'b0, 1'b0, 0, 0, y, s);

    // Reset in MAC cycle 7
    in_valid = 1'b1; xn = 16'sd20000;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    check("mid busy", longint'(busy), 1);
    rst_n = 1'b0;
    for (int k = 0; k < TAPS; k++) begin mx[k] = 0; mc[k] = 0; end
    step();
    check("mid reset", longint'({out_valid, in_ready, busy}) * 100000 + longint'(yn),
          longint'(3'b010) * 100000);
    rst_n = 1'b1;
    step();
    run_sample("post_reset_imp", 16384, 1'b0, 1'b0, 0, 0, y, s);
    check("post_reset const", y, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fir_mac_tdm.md
Name: fir_mac_tdm

Overview:
- Parametrised, time-multiplexed FIR equaliser filter; successor to the 15-tap fully parallel filter.
- One shared multiplier-accumulator processes TAPS products per input sample.
- Coefficients are runtime-loadable through a register port.
- Input and output use valid/ready handshakes; the output is rounded and saturated.
- Sits between the sample source (ADC/deserialiser side) and the equaliser output stage.

Parameters:
- DATA_W, 16: signed input sample width.
- COEF_W, 16: signed coefficient width.
- OUT_W, 16: signed output width.
- TAPS, 16: number of taps; must be at least 2.
- FRAC_BITS, 14: right shift applied to the accumulator (Q2.14 coefficients); must be at least 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index to write.
- coef_wdata  in  COEF_W  signed coefficient value.
- in_valid  in  1  xn is valid.
- in_ready  out  1  block can accept a sample.
- xn  in  DATA_W  signed input sample.
- out_valid  out  1  yn is valid.
- out_ready  in  1  downstream accepts yn.
- yn  out  OUT_W  signed filtered output.
- sat  out  1  current yn was clipped; qualified by out_valid.
- busy  out  1  high in MAC or OUT state.

Behaviour:
- Reset (asynchronous, immediate):
  - Delay line, coefficients, accumulator and tap counter all clear to 0.
  - FSM returns to IDLE.
  - Outputs: in_ready=1, out_valid=0, yn=0, sat=0, busy=0.
  - Reset mid-MAC or mid-OUT aborts the sample in flight; no output is produced for it.
- Storage:
  - Delay line x[0..TAPS-1], DATA_W each.
  - Coefficient bank c[0..TAPS-1], COEF_W each.
- FSM has three states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: x[0]<=xn and x[k]<=x[k-1] for k≥1; acc<=0; tap index<=0; go to MAC.
- MAC:
  - in_ready=0.
  - Each cycle: acc<=acc+x[i]*c[i] (full-precision signed), then i<=i+1.
  - After the i=TAPS-1 product: go to OUT, with yn and sat registered on that same edge.
  - Exactly TAPS cycles are spent in MAC.
- OUT:
  - out_valid=1; yn and sat are held stable until out_ready=1.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE.
  - in_ready is still 0 in OUT; no overlap with the next sample.
- Latency: the sample is accepted at edge T; out_valid rises at edge T+TAPS.
  - Minimum sample period is TAPS+2 cycles with out_ready held at 1.
- Arithmetic:
  - Accumulator width ACC_W = DATA_W+COEF_W+$clog2(TAPS); no overflow is possible.
  - Rounding: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. arithmetic shift, round half toward +inf.
  - Saturation bounds: [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If r exceeds a bound, yn takes that bound and sat=1; otherwise yn=r[OUT_W-1:0] and sat=0.
- Coefficient port:
  - A write takes effect on the edge coef_we is high, only while in IDLE.
  - Writes while busy=1 are dropped silently; software polls busy.
  - A write and a sample accept on the same IDLE edge are both performed; the new coefficient is used for that sample.
  - coef_addr ≥ TAPS (non-power-of-2 TAPS): the write is ignored.
- Other conditions:
  - in_valid held high continuously: samples are accepted only in IDLE, one per pass.
  - xn is don't-care when in_valid=0.

Test Plan:
- Unity tap: c[0]=16384, all other taps 0; feed xn=1000 → yn=1000, sat=0; out_valid rises exactly TAPS=16 edges after accept.
- Impulse response: c[k]=1024*(k+1); feed 16384 followed by 15 zeros → yn sequence 1024, 2048, …, 16384.
- Rounding: c[0]=1, others 0; xn=8192 → yn=1; xn=8191 → yn=0; xn=-8192 → yn=0; xn=-8193 → yn=-1.
- Saturation, positive: all c=32767, feed 16 samples of 32767 → final yn=32767, sat=1.
- Saturation, negative: all c=32767, feed 16 samples of -32768 → yn=-32768, sat=1.
- Backpressure and protection:
  - Hold out_ready=0 for 5 cycles in OUT → yn and sat stable, in_ready=0.
  - A coef_we pulse during MAC leaves c unchanged (read back via a repeat of the unity test).
- Reset mid-operation: assert rst_n=0 at MAC cycle 7 → next edge shows out_valid=0, in_ready=1, yn=0.
  - A subsequent impulse input produces zero output, since coefficients were cleared.
